// File: rtl/output_layer_pkg.sv
// Shared constants, FSM encoding and W-channel payload for the output-layer DDR writer.
package output_layer_pkg;

  localparam int unsigned LAYER_STRIDE_SHIFT = 12;
  localparam int unsigned ROW_STRIDE_SHIFT   = 6;
  localparam int unsigned AXI_DATA_W         = 64;
  localparam int unsigned AXI_STRB_W         = AXI_DATA_W / 8;

  localparam logic [2:0] AXI_SIZE_8B          = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR       = 2'd1;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wr_state_e;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } w_beat_t;

  // Strobe for the final beat of a row holding rem valid bytes (0 means a full beat).
  function automatic logic [AXI_STRB_W-1:0] last_beat_strb(input logic [2:0] rem);
    logic [AXI_STRB_W-1:0] strb;
    strb = '0;
    if (rem == 3'd0) begin
      strb = '1;
    end else begin
      for (int i = 0; i < int'(AXI_STRB_W); i++) begin
        if (i < int'(rem)) strb[i] = 1'b1;
      end
    end
    return strb;
  endfunction

endpackage

// File: rtl/output_layer_writer_row_pack_buffer.sv
// Ping-pong pair of row banks: packs pixels into byte lanes and hands full rows to the AXI drain.
module row_pack_buffer #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned BEAT_W  = 3,
  parameter int unsigned LANE_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [PIXEL_W-1:0] wr_pix,
  input  logic              wr_last,
  input  logic [BEAT_W-1:0] rd_beat,
  input  logic              rd_free,
  output logic              fill_free_c,
  output logic              drain_full_c,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] bank_mem [2][BEATS];
  logic [1:0]        full_q;
  logic              fill_sel_q;
  logic              drain_sel_q;

  // Lane 0 rewrites the whole beat so lanes past the row end read back as zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_lane == '0) begin
        bank_mem[fill_sel_q][wr_beat] <= DATA_W'(wr_pix);
      end else begin
        bank_mem[fill_sel_q][wr_beat][wr_lane*PIXEL_W +: PIXEL_W] <= wr_pix;
      end
    end
  end

  // Fill and drain always touch different banks, so both updates may land in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q      <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
    end else begin
      if (wr_en && wr_last) begin
        full_q[fill_sel_q] <= 1'b1;
        fill_sel_q         <= ~fill_sel_q;
      end
      if (rd_free) begin
        full_q[drain_sel_q] <= 1'b0;
        drain_sel_q         <= ~drain_sel_q;
      end
    end
  end

  assign fill_free_c  = ~full_q[fill_sel_q];
  assign drain_full_c = full_q[drain_sel_q];
  assign rd_data_c    = bank_mem[drain_sel_q][rd_beat];

endmodule

// File: rtl/output_layer_writer.sv
// AXI4 write master: streams output-layer pixels into DDR3, one INCR burst per (row, layer).
module output_layer_writer
  import output_layer_pkg::*;
#(
  parameter int unsigned C_M_AXI_ID_WIDTH   = 3,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned MAX_ROW_BEATS      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [31:0]                     axi_base_address,
  input  logic [9:0]                      no_of_output_layers,
  input  logic [9:0]                      output_layer_row_size,
  input  logic [9:0]                      output_layer_col_size,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            wr_err,
  input  logic [PIXEL_WIDTH-1:0]          out_data,
  input  logic                            out_valid,
  output logic                            out_rdy,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
  output logic [7:0]                      M_axi_awlen,
  output logic [2:0]                      M_axi_awsize,
  output logic [1:0]                      M_axi_awburst,
  output logic                            M_axi_awlock,
  output logic [3:0]                      M_axi_awcache,
  output logic [2:0]                      M_axi_awprot,
  output logic [3:0]                      M_axi_awqos,
  output logic                            M_axi_awvalid,
  input  logic                            M_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
  output logic                            M_axi_wlast,
  output logic                            M_axi_wvalid,
  input  logic                            M_axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_axi_bid,
  input  logic [1:0]                      M_axi_bresp,
  input  logic                            M_axi_bvalid,
  output logic                            M_axi_bready
);

  localparam int unsigned LANES    = C_M_AXI_DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned LANE_W   = $clog2(LANES);
  localparam int unsigned BEAT_W   = $clog2(MAX_ROW_BEATS);
  localparam int unsigned COL_W    = LANE_W + BEAT_W;
  localparam int unsigned MAX_COLS = MAX_ROW_BEATS * LANES;

  wr_state_e state, state_nx;

  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_base;
  logic [9:0]                    cfg_layers, cfg_rows;
  logic [COL_W:0]                cfg_col;
  logic [AXI_STRB_W-1:0]         cfg_last_strb;

  logic [COL_W-1:0] col_cnt;
  logic [9:0]       f_layer, f_row, d_layer, d_row;
  logic             fill_done;

  w_beat_t                       w_q, w_nx;
  logic [BEAT_W-1:0]             beat_q, beat_nx;
  logic                          awvalid_nx, wvalid_nx, bready_nx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_nx, drain_addr_c;

  logic                          cfg_bad_c, pix_acc_c, row_end_c, frame_end_c;
  logic                          fill_free_c, drain_full_c, buf_free_c, b_done_c;
  logic [BEAT_W-1:0]             rd_beat_c;
  logic [C_M_AXI_DATA_WIDTH-1:0] rd_data_c;
  logic                          unused_bid;

  assign unused_bid = ^M_axi_bid;

  assign M_axi_awid    = '0;
  assign M_axi_awsize  = AXI_SIZE_8B;
  assign M_axi_awburst = AXI_BURST_INCR;
  assign M_axi_awlock  = 1'b0;
  assign M_axi_awcache = AXI_CACHE_MODIFIABLE;
  assign M_axi_awprot  = '0;
  assign M_axi_awqos   = '0;
  assign M_axi_wdata   = C_M_AXI_DATA_WIDTH'(w_q.data);
  assign M_axi_wstrb   = (C_M_AXI_DATA_WIDTH/8)'(w_q.strb);
  assign M_axi_wlast   = w_q.last;

  assign cfg_bad_c   = (output_layer_col_size == 10'd0) || (output_layer_col_size > 10'(MAX_COLS)) ||
                       (output_layer_row_size == 10'd0) || (no_of_output_layers == 10'd0);
  assign out_rdy     = busy & ~fill_done & fill_free_c;
  assign pix_acc_c   = out_valid & out_rdy;
  assign row_end_c   = (col_cnt == COL_W'(cfg_col - 1'b1));
  assign frame_end_c = (d_layer == cfg_layers - 10'd1) && (d_row == cfg_rows - 10'd1);
  assign drain_addr_c = cfg_base
                      + (C_M_AXI_ADDR_WIDTH'(d_layer) << LAYER_STRIDE_SHIFT)
                      + (C_M_AXI_ADDR_WIDTH'(d_row) << ROW_STRIDE_SHIFT);

  row_pack_buffer #(
    .PIXEL_W (PIXEL_WIDTH),
    .DATA_W  (C_M_AXI_DATA_WIDTH),
    .BEATS   (MAX_ROW_BEATS),
    .BEAT_W  (BEAT_W),
    .LANE_W  (LANE_W)
  ) u_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (pix_acc_c),
    .wr_beat      (col_cnt[COL_W-1:LANE_W]),
    .wr_lane      (col_cnt[LANE_W-1:0]),
    .wr_pix       (out_data),
    .wr_last      (row_end_c),
    .rd_beat      (rd_beat_c),
    .rd_free      (buf_free_c),
    .fill_free_c  (fill_free_c),
    .drain_full_c (drain_full_c),
    .rd_data_c    (rd_data_c)
  );

  // Job control, fill-side counters and drain-side (burst) counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_err        <= 1'b0;
      cfg_base      <= '0;
      cfg_layers    <= '0;
      cfg_rows      <= '0;
      cfg_col       <= '0;
      M_axi_awlen   <= '0;
      cfg_last_strb <= '0;
      col_cnt       <= '0;
      f_layer       <= '0;
      f_row         <= '0;
      d_layer       <= '0;
      d_row         <= '0;
      fill_done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        if (cfg_bad_c) begin
          wr_err <= 1'b1;
        end else begin
          busy          <= 1'b1;
          cfg_base      <= C_M_AXI_ADDR_WIDTH'(axi_base_address);
          cfg_layers    <= no_of_output_layers;
          cfg_rows      <= output_layer_row_size;
          cfg_col       <= (COL_W+1)'(output_layer_col_size);
          M_axi_awlen   <= 8'((output_layer_col_size - 10'd1) >> LANE_W);
          cfg_last_strb <= last_beat_strb(output_layer_col_size[2:0]);
          col_cnt       <= '0;
          f_layer       <= '0;
          f_row         <= '0;
          d_layer       <= '0;
          d_row         <= '0;
          fill_done     <= 1'b0;
        end
      end
      if (pix_acc_c) begin
        if (row_end_c) begin
          col_cnt <= '0;
          if (f_layer == cfg_layers - 10'd1) begin
            f_layer <= '0;
            if (f_row == cfg_rows - 10'd1) fill_done <= 1'b1;
            else                           f_row     <= f_row + 10'd1;
          end else begin
            f_layer <= f_layer + 10'd1;
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (b_done_c) begin
        if (M_axi_bresp != 2'b00) wr_err <= 1'b1;
        if (frame_end_c) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else if (d_layer == cfg_layers - 10'd1) begin
          d_layer <= '0;
          d_row   <= d_row + 10'd1;
        end else begin
          d_layer <= d_layer + 10'd1;
        end
      end
    end
  end

  // Write FSM state and registered AXI channel outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      M_axi_awvalid <= 1'b0;
      M_axi_awaddr  <= '0;
      M_axi_wvalid  <= 1'b0;
      M_axi_bready  <= 1'b0;
      w_q           <= '0;
      beat_q        <= '0;
    end else begin
      state         <= state_nx;
      M_axi_awvalid <= awvalid_nx;
      M_axi_awaddr  <= awaddr_nx;
      M_axi_wvalid  <= wvalid_nx;
      M_axi_bready  <= bready_nx;
      w_q           <= w_nx;
      beat_q        <= beat_nx;
    end
  end

  // Next-state and next-output logic; the next beat is fetched as the current one is accepted.
  always_comb begin
    state_nx   = state;
    awvalid_nx = M_axi_awvalid;
    awaddr_nx  = M_axi_awaddr;
    wvalid_nx  = M_axi_wvalid;
    bready_nx  = M_axi_bready;
    w_nx       = w_q;
    beat_nx    = beat_q;
    rd_beat_c  = beat_q;
    buf_free_c = 1'b0;
    b_done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (busy && drain_full_c) begin
          state_nx   = ST_AW;
          awvalid_nx = 1'b1;
          awaddr_nx  = drain_addr_c;
        end
      end
      ST_AW: begin
        if (M_axi_awready) begin
          state_nx   = ST_W;
          awvalid_nx = 1'b0;
          wvalid_nx  = 1'b1;
          rd_beat_c  = '0;
          beat_nx    = '0;
          w_nx.data  = AXI_DATA_W'(rd_data_c);
          w_nx.last  = (M_axi_awlen == 8'd0);
          w_nx.strb  = w_nx.last ? cfg_last_strb : '1;
        end
      end
      ST_W: begin
        if (M_axi_wready) begin
          if (w_q.last) begin
            state_nx   = ST_B;
            wvalid_nx  = 1'b0;
            w_nx.last  = 1'b0;
            bready_nx  = 1'b1;
            buf_free_c = 1'b1;
          end else begin
            rd_beat_c = BEAT_W'(beat_q + 1'b1);
            beat_nx   = rd_beat_c;
            w_nx.data = AXI_DATA_W'(rd_data_c);
            w_nx.last = (rd_beat_c == M_axi_awlen[BEAT_W-1:0]);
            w_nx.strb = w_nx.last ? cfg_last_strb : '1;
          end
        end
      end
      ST_B: begin
        if (M_axi_bvalid) begin
          state_nx  = ST_IDLE;
          bready_nx = 1'b0;
          b_done_c  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
